// File: rtl/toggle_period_monitor.sv
// Purpose: measures edge-to-edge period of an async toggling pin, flags tolerance, lock and stall.
// Latency: in_pin change -> edge seen 2-3 cycles later -> period_valid/period_out one cycle after that.
// Backpressure: none; period_valid is a one-cycle pulse and is never held for a consumer.
//
// Ports:
//   clk          system clock (single domain)
//   rst_n        asynchronous active-low reset
//   in_pin       asynchronous toggling input, both polarities counted as edges
//   period_out   last measured edge-to-edge period in clk cycles
//   period_valid one-cycle pulse when period_out/in_tol update
//   in_tol       period_out within EXPECTED +/- TOLERANCE
//   locked       LOCK_COUNT consecutive in-tolerance periods seen
//   stall        sticky: no edge within EXPECTED + TOLERANCE cycles; cleared by next edge
//   level_out    top 5 bits of the running counter, one cycle late (LED progress bar)
module toggle_period_monitor #(
    parameter int CNT_W      = 26,
    parameter int EXPECTED   = 60000000,
    parameter int TOLERANCE  = 1024,
    parameter int LOCK_COUNT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_pin,
    output logic [CNT_W-1:0] period_out,
    output logic             period_valid,
    output logic             in_tol,
    output logic             locked,
    output logic             stall,
    output logic [4:0]       level_out
);

    localparam int STRK_W = $clog2(LOCK_COUNT + 1);

    localparam logic [STRK_W-1:0] STRK_MAX = STRK_W'(LOCK_COUNT);
    localparam logic [CNT_W-1:0]  TOL_HI   = CNT_W'(EXPECTED + TOLERANCE);
    // One guard bit so run_cnt + TOLERANCE can never wrap.
    localparam logic [CNT_W:0]    EXP_X    = (CNT_W + 1)'(EXPECTED);
    localparam logic [CNT_W:0]    TOL_X    = (CNT_W + 1)'(TOLERANCE);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic              sync1, sync2, prev;
    logic              edge_det;
    logic [CNT_W-1:0]  run_cnt;
    logic [STRK_W-1:0] streak, streak_nxt;
    logic              in_tol_c, lo_ok, hi_ok;
    logic              locked_nxt, stall_nxt, in_tol_nxt, pvld_nxt;
    logic [CNT_W-1:0]  period_nxt;

    // Two-flop synchroniser plus history flop; any level change is an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= in_pin;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign edge_det = sync2 ^ prev;

    // Reload to 1 on an edge so the value seen at the next edge is the period itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt <= '0;
        end else if (edge_det) begin
            run_cnt <= CNT_W'(1);
        end else if (run_cnt != {CNT_W{1'b1}}) begin
            run_cnt <= run_cnt + 1'b1;
        end
    end

    // |run_cnt - EXPECTED| <= TOLERANCE without underflow: the lower bound is
    // checked as run_cnt + TOLERANCE >= EXPECTED, which clamps EXPECTED-TOLERANCE at 0.
    assign lo_ok    = ({1'b0, run_cnt} + TOL_X) >= EXP_X;
    assign hi_ok    = run_cnt <= TOL_HI;
    assign in_tol_c = lo_ok && hi_ok;

    always_comb begin
        state_nxt  = state;
        streak_nxt = streak;
        locked_nxt = locked;
        stall_nxt  = stall;
        in_tol_nxt = in_tol;
        period_nxt = period_out;
        pvld_nxt   = 1'b0;
        case (state)
            IDLE: begin
                // First edge only establishes a reference; nothing to report yet.
                if (edge_det) begin
                    state_nxt  = MEASURE;
                    stall_nxt  = 1'b0;
                    streak_nxt = '0;
                end
            end
            MEASURE, LOCKED: begin
                if (edge_det) begin
                    period_nxt = run_cnt;
                    pvld_nxt   = 1'b1;
                    in_tol_nxt = in_tol_c;
                    if (in_tol_c) begin
                        if (streak != STRK_MAX) begin
                            streak_nxt = streak + 1'b1;
                        end
                        if (streak_nxt == STRK_MAX) begin
                            state_nxt  = LOCKED;
                            locked_nxt = 1'b1;
                        end
                    end else begin
                        streak_nxt = '0;
                        locked_nxt = 1'b0;
                        state_nxt  = MEASURE;
                    end
                end else if (run_cnt > TOL_HI) begin
                    // An edge in this same cycle wins above, so it is reported
                    // as a late period rather than a stall.
                    stall_nxt  = 1'b1;
                    locked_nxt = 1'b0;
                    streak_nxt = '0;
                    state_nxt  = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            streak       <= '0;
            period_out   <= '0;
            period_valid <= 1'b0;
            in_tol       <= 1'b0;
            locked       <= 1'b0;
            stall        <= 1'b0;
            level_out    <= '0;
        end else begin
            state        <= state_nxt;
            streak       <= streak_nxt;
            period_out   <= period_nxt;
            period_valid <= pvld_nxt;
            in_tol       <= in_tol_nxt;
            locked       <= locked_nxt;
            stall        <= stall_nxt;
            level_out    <= run_cnt[CNT_W-1 -: 5];
        end
    end

endmodule

// File: tb/tb_toggle_period_monitor.sv
// Purpose: directed self-checking bench for toggle_period_monitor (CNT_W=8, EXPECTED=100, TOL=2, LOCK=2).
// Latency: in_pin toggled just after a posedge shows period_valid after the 3rd following posedge.
// Backpressure: none in the DUT; stimulus is purely time-driven.
module tb_toggle_period_monitor;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_pin = 1'b0;
    logic [CNT_W-1:0] period_out;
    logic             period_valid;
    logic             in_tol;
    logic             locked;
    logic             stall;
    logic [4:0]       level_out;

    int n_cmp = 0;
    int n_bad = 0;
    int since_tog = 0;

    toggle_period_monitor #(
        .CNT_W      (CNT_W),
        .EXPECTED   (100),
        .TOLERANCE  (2),
        .LOCK_COUNT (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_pin       (in_pin),
        .period_out   (period_out),
        .period_valid (period_valid),
        .in_tol       (in_tol),
        .locked       (locked),
        .stall        (stall),
        .level_out    (level_out)
    );

    always #5 clk = ~clk;

    // Advance n posedges and land 1 time unit after the last one.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
        since_tog += n;
    endtask

    // Toggle in_pin exactly n cycles after the previous toggle.
    task automatic toggle_at(input int n);
        if (n > since_tog) cyc(n - since_tog);
        in_pin = ~in_pin;
        since_tog = 0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        cyc(2);
        in_pin = 1'b1;
        cyc(2);
        in_pin = 1'b0;
        cyc(2);
        n_cmp++; if (period_out !== 8'd0) begin n_bad++; $display("FAIL rst_period_out: got %0d want 0", period_out); end
        n_cmp++; if (period_valid !== 1'b0) begin n_bad++; $display("FAIL rst_period_valid: got %b want 0", period_valid); end
        n_cmp++; if (in_tol !== 1'b0) begin n_bad++; $display("FAIL rst_in_tol: got %b want 0", in_tol); end
        n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL rst_locked: got %b want 0", locked); end
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall: got %b want 0", stall); end
        n_cmp++; if (level_out !== 5'd0) begin n_bad++; $display("FAIL rst_level: got %0d want 0", level_out); end
        rst_n = 1'b1;
        since_tog = 0;
        // Counter runs in IDLE: after 40 cycles run_cnt=40, level_out sees 39 -> 39>>3 = 4.
        cyc(40);
        n_cmp++; if (level_out !== 5'd4) begin n_bad++; $display("FAIL idle_level: got %0d want 4", level_out); end
        toggle_at(40);
        cyc(3);
        n_cmp++; if (period_valid !== 1'b0) begin n_bad++; $display("FAIL first_edge_no_valid: got %b want 0", period_valid); end
        n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL first_edge_locked: got %b want 0", locked); end
    endtask

    task automatic test_steady;
        toggle_at(100);
        cyc(3);
        n_cmp++; if (period_valid !== 1'b1) begin n_bad++; $display("FAIL steady1_valid: got %b want 1", period_valid); end
        n_cmp++; if (period_out !== 8'd100) begin n_bad++; $display("FAIL steady1_period: got %0d want 100", period_out); end
        n_cmp++; if (in_tol !== 1'b1) begin n_bad++; $display("FAIL steady1_in_tol: got %b want 1", in_tol); end
        n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL steady1_locked: got %b want 0", locked); end
        n_cmp++; if (level_out !== 5'd12) begin n_bad++; $display("FAIL steady1_level: got %0d want 12", level_out); end
        cyc(1);
        n_cmp++; if (period_valid !== 1'b0) begin n_bad++; $display("FAIL steady1_pulse_width: got %b want 0", period_valid); end
        n_cmp++; if (period_out !== 8'd100) begin n_bad++; $display("FAIL steady1_hold: got %0d want 100", period_out); end
        toggle_at(100);
        cyc(3);
        n_cmp++; if (period_valid !== 1'b1) begin n_bad++; $display("FAIL steady2_valid: got %b want 1", period_valid); end
        n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL steady2_locked: got %b want 1", locked); end
        toggle_at(100);
        cyc(3);
        n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL steady3_locked: got %b want 1", locked); end
        n_cmp++; if (period_out !== 8'd100) begin n_bad++; $display("FAIL steady3_period: got %0d want 100", period_out); end
    endtask

    task automatic test_boundaries;
        int per[8]      = '{98, 102, 97, 100, 100, 103, 100, 100};
        logic exp_tol[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic exp_lck[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            toggle_at(per[i]);
            cyc(3);
            n_cmp++; if (period_valid !== 1'b1) begin n_bad++; $display("FAIL bound%0d_valid: got %b want 1", i, period_valid); end
            n_cmp++; if (period_out !== CNT_W'(per[i])) begin n_bad++; $display("FAIL bound%0d_period: got %0d want %0d", i, period_out, per[i]); end
            n_cmp++; if (in_tol !== exp_tol[i]) begin n_bad++; $display("FAIL bound%0d_in_tol: got %b want %b", i, in_tol, exp_tol[i]); end
            n_cmp++; if (locked !== exp_lck[i]) begin n_bad++; $display("FAIL bound%0d_locked: got %b want %b", i, locked, exp_lck[i]); end
        end
    endtask

    task automatic test_stall;
        toggle_at(100);
        cyc(3);
        n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL stall_pre_locked: got %b want 1", locked); end
        // Edge registered at since_tog=3; run_cnt=103 during the cycle ending at since_tog=106.
        cyc(102);
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL stall_early: got %b want 0", stall); end
        n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL stall_early_locked: got %b want 1", locked); end
        cyc(1);
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL stall_set: got %b want 1", stall); end
        n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL stall_locked: got %b want 0", locked); end
        n_cmp++; if (period_valid !== 1'b0) begin n_bad++; $display("FAIL stall_valid: got %b want 0", period_valid); end
        cyc(20);
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL stall_sticky: got %b want 1", stall); end
        toggle_at(150);
        cyc(3);
        n_cmp++; if (period_valid !== 1'b0) begin n_bad++; $display("FAIL stall_reedge_valid: got %b want 0", period_valid); end
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL stall_clear: got %b want 0", stall); end
        toggle_at(100);
        cyc(3);
        n_cmp++; if (period_valid !== 1'b1) begin n_bad++; $display("FAIL stall_next_valid: got %b want 1", period_valid); end
        n_cmp++; if (period_out !== 8'd100) begin n_bad++; $display("FAIL stall_next_period: got %0d want 100", period_out); end
        n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL stall_next_locked: got %b want 0", locked); end
    endtask

    task automatic test_simultaneous;
        toggle_at(100);
        cyc(3);
        n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL simul_pre_locked: got %b want 1", locked); end
        toggle_at(103);
        cyc(3);
        n_cmp++; if (period_valid !== 1'b1) begin n_bad++; $display("FAIL simul_valid: got %b want 1", period_valid); end
        n_cmp++; if (period_out !== 8'd103) begin n_bad++; $display("FAIL simul_period: got %0d want 103", period_out); end
        n_cmp++; if (in_tol !== 1'b0) begin n_bad++; $display("FAIL simul_in_tol: got %b want 0", in_tol); end
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL simul_stall: got %b want 0", stall); end
        n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL simul_locked: got %b want 0", locked); end
        cyc(5);
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL simul_stall_later: got %b want 0", stall); end
    endtask

    task automatic test_async_reset;
        toggle_at(100);
        toggle_at(100);
        cyc(3);
        n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL arst_pre_locked: got %b want 1", locked); end
        cyc(40);
        rst_n = 1'b0;
        #2;
        n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL arst_locked: got %b want 0", locked); end
        n_cmp++; if (period_out !== 8'd0) begin n_bad++; $display("FAIL arst_period: got %0d want 0", period_out); end
        n_cmp++; if (in_tol !== 1'b0) begin n_bad++; $display("FAIL arst_in_tol: got %b want 0", in_tol); end
        n_cmp++; if (level_out !== 5'd0) begin n_bad++; $display("FAIL arst_level: got %0d want 0", level_out); end
        in_pin = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        since_tog = 0;
        cyc(30);
        n_cmp++; if (period_valid !== 1'b0) begin n_bad++; $display("FAIL arst_quiet_valid: got %b want 0", period_valid); end
        toggle_at(30);
        cyc(3);
        n_cmp++; if (period_valid !== 1'b0) begin n_bad++; $display("FAIL arst_first_valid: got %b want 0", period_valid); end
        toggle_at(100);
        cyc(3);
        n_cmp++; if (period_valid !== 1'b1) begin n_bad++; $display("FAIL arst_p1_valid: got %b want 1", period_valid); end
        n_cmp++; if (period_out !== 8'd100) begin n_bad++; $display("FAIL arst_p1_period: got %0d want 100", period_out); end
        n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL arst_p1_locked: got %b want 0", locked); end
        toggle_at(100);
        cyc(3);
        n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL arst_p2_locked: got %b want 1", locked); end
    endtask

    initial begin
        test_reset();
        test_steady();
        test_boundaries();
        test_stall();
        test_simultaneous();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/toggle_period_monitor.md
Name: toggle_period_monitor

Overview:
- Receiver-side companion to the board's divided-clock toggle output. Samples an external toggling pin and measures the time between consecutive edges in clk cycles.
- Checks each measured period against an expected half-period with tolerance, and reports lock, stall and a 5-bit progress value for LEDs.
- Used for board-to-board loopback checks and for verifying a reconfigured bitstream's blink rate.

Parameters:
- CNT_W, 26, width of the period counter and of period_out (minimum 6).
- EXPECTED, 60000000, nominal cycles between consecutive edges; must be less than 2^CNT_W - 1 - TOLERANCE.
- TOLERANCE, 1024, allowed absolute deviation from EXPECTED, in cycles.
- LOCK_COUNT, 2, consecutive in-tolerance periods required to assert locked (minimum 1).

Ports:
- clk  input  1  system clock, single clock domain.
- rst_n  input  1  asynchronous active-low reset.
- in_pin  input  1  asynchronous toggling input.
- period_out  output  CNT_W  last measured edge-to-edge period, in cycles.
- period_valid  output  1  one-cycle pulse when period_out updates.
- in_tol  output  1  registered with period_out; 1 when that period is within tolerance.
- locked  output  1  stable-rate indication.
- stall  output  1  sticky no-edge timeout flag.
- level_out  output  5  bits [CNT_W-1:CNT_W-5] of the running counter.

Behaviour:
- Reset: rst_n low asynchronously clears everything.
  - State goes to IDLE.
  - run_cnt, period_out, period_valid, in_tol, locked, stall, level_out and the lock streak counter all go to 0.
  - Synchroniser flops and the previous-sample flop go to 0.
  - Reset may assert mid-measurement; no partial period is reported after release.
- Input path:
  - Two-flop synchroniser, then a previous-sample flop.
  - edge = sync2 XOR prev, with both edge polarities counted.
  - An in_pin transition is seen as edge 2 to 3 cycles later.
  - period_valid rises on the cycle after edge.
- run_cnt (CNT_W bits):
  - On an edge cycle, run_cnt <= 1.
  - Otherwise run_cnt <= run_cnt + 1, saturating at all-ones and never wrapping.
  - At an edge, run_cnt equals the number of cycles since the previous edge.
- State machine states: IDLE, MEASURE, LOCKED.
  - IDLE:
    - On an edge: go to MEASURE, clear stall, reload run_cnt. No period_valid (first edge has no reference).
    - No timeout is checked in IDLE.
  - MEASURE and LOCKED, on an edge:
    - period_out <= run_cnt; period_valid <= 1.
    - in_tol <= (|run_cnt - EXPECTED| <= TOLERANCE), computed unsigned without overflow: compare run_cnt against EXPECTED-TOL and EXPECTED+TOL, clamping EXPECTED-TOL at 0.
    - If in tolerance: the streak counter increments, saturating at LOCK_COUNT. When it reaches LOCK_COUNT, go to LOCKED and set locked=1 in the same cycle as period_valid.
    - If out of tolerance: streak <= 0, locked <= 0, go to MEASURE.
  - MEASURE and LOCKED, with no edge and run_cnt > EXPECTED + TOLERANCE (timeout):
    - stall <= 1, locked <= 0, streak <= 0, go to IDLE.
    - The timeout fires exactly on the cycle run_cnt first holds EXPECTED+TOLERANCE+1.
    - An edge arriving in that same cycle takes priority: it counts as an out-of-tolerance period and no stall is raised.
- stall stays 1 until the next edge, which is taken from IDLE.
- Output registers:
  - period_out and in_tol hold their value between updates.
  - period_valid is 0 at all times except the single update cycle.
- level_out is registered from run_cnt, one cycle behind run_cnt.
- Edges closer than 1 cycle apart after synchronisation (glitches) are simply measured as short periods; there is no filtering.

Test Plan (CNT_W=8, EXPECTED=100, TOLERANCE=2, LOCK_COUNT=2):
- Reset check: hold rst_n low, toggle in_pin → all outputs 0. Release rst_n, first edge → no period_valid, state MEASURE.
- Steady toggle every 100 cycles → each subsequent edge gives period_out=100, in_tol=1. locked=1 together with the second valid pulse and stays 1.
- Boundaries: periods 98, 102, 97, 103 → in_tol = 1, 1, 0, 0. A 97 or 103 period while locked drops locked in the same cycle as its period_valid.
- Stall: after lock, stop toggling → stall=1 and locked=0 on the cycle run_cnt=103; no period_valid. The next edge clears stall with no period report; the edge after that reports its period.
- Simultaneous: an edge timed to be detected exactly when run_cnt=103 → period_out=103, in_tol=0, stall stays 0.
- Async reset asserted mid-period while locked → outputs 0 immediately. After release, the first edge produces no period_valid and locked needs 2 new in-tolerance periods.
